control_sequencer: RTL

- Hardwired control unit that drives the datapath control inputs, replacing the manual T-state sequencing used in bench stimulus.
- Fetches through PC/MAR/MDR/IR, decodes IR[31:27], and issues per-step register and bus strobes.
- Supported opcodes: in, out, mfhi, mflo, add, sub, and, or, nop, halt.
- Sits beside the datapath. Its outputs connect one-to-one to the datapath control ports.

---
 rtl/cpu_pkg.sv | 55 +++++
 rtl/cs_wait_timer.sv | 35 +++
 rtl/control_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control unit: opcode map of the ISA,
// sequencer state encoding and a small opcode-class helper.
package cpu_pkg;

  localparam int OPC_WIDTH  = 5;
  localparam int WAIT_CNT_W = 4;

  // Full ISA opcode map (IR[31:27]); only a subset is sequenced here.
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  // Sequencer states, 4-bit encoding.
  typedef enum logic [3:0] {
    ST_T0     = 4'd0,
    ST_T1     = 4'd1,
    ST_T1W    = 4'd2,
    ST_T2     = 4'd3,
    ST_T3     = 4'd4,
    ST_T4     = 4'd5,
    ST_T5     = 4'd6,
    ST_HALTED = 4'd7,
    ST_PAUSE  = 4'd8
  } cs_state_e;

  // Three-operand register ALU instructions that need the T4/T5 steps.
  function automatic logic is_alu_op(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/cs_wait_timer.sv
// Memory-wait counter used while the sequencer sits in T1W.
// cnt_start loads 1, cnt_inc counts up, cnt_clear zeroes; expire flags the
// cycle in which the count has reached MEM_TIMEOUT.
module cs_wait_timer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = WAIT_CNT_W
) (
  input  logic Clock,
  input  logic Clear,
  input  logic cnt_start,
  input  logic cnt_clear,
  input  logic cnt_inc,
  output logic expire
);

  logic [CNT_W-1:0] count_reg;

  // Wait-cycle counter; clear wins over start, start wins over increment.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      count_reg <= '0;
    end else if (cnt_clear) begin
      count_reg <= '0;
    end else if (cnt_start) begin
      count_reg <= CNT_W'(1);
    end else if (cnt_inc) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign expire = (count_reg == CNT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch (T0-T2), decode of the latched opcode and
// per-step datapath strobes (T3-T5). Moore outputs, forced low while Clear
// is asserted so no strobe survives a reset.
// Optional build macro CU_SINGLE_STEP_EN: adds the Step input and a PAUSE
// state so that one instruction executes per rising edge of Step.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int OPC_W       = OPC_WIDTH,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic [OPC_W-1:0] IR_opcode,
  input  logic             Mem_ready,
  input  logic             Stop,
`ifdef CU_SINGLE_STEP_EN
  input  logic             Step,
`endif
  output logic             PCout,
  output logic             MAR_enable,
  output logic             IncPC,
  output logic             PC_enable,
  output logic             ZLowIn,
  output logic             ZLowout,
  output logic             MDR_read,
  output logic             MDR_enable,
  output logic             MDRout,
  output logic             IR_enable,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             R_in,
  output logic             R_out,
  output logic             Y_enable,
  output logic             InPortout,
  output logic             OutPort_enable,
  output logic             HIout,
  output logic             LOout,
  output logic [OPC_W-1:0] ALU_op,
  output logic             Run,
  output logic             Mem_fault
);

`ifdef CU_SINGLE_STEP_EN
  localparam cs_state_e DONE_STATE = ST_PAUSE;
`else
  localparam cs_state_e DONE_STATE = ST_T0;
`endif

  cs_state_e        state_reg, state_next;
  logic [OPC_W-1:0] opcode_reg;
  logic             mem_fault_reg;
  logic             timer_start, timer_inc, timer_clear, timer_expire;

  // Wait counter runs only while T1 or T1W is still waiting for memory.
  assign timer_start = (state_reg == ST_T1)  && !Mem_ready;
  assign timer_inc   = (state_reg == ST_T1W) && !Mem_ready && !timer_expire;
  assign timer_clear = !timer_start && !timer_inc;

  cs_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (WAIT_CNT_W)
  ) u_wait_timer (
    .Clock     (Clock),
    .Clear     (Clear),
    .cnt_start (timer_start),
    .cnt_clear (timer_clear),
    .cnt_inc   (timer_inc),
    .expire    (timer_expire)
  );

`ifdef CU_SINGLE_STEP_EN
  logic step_prev_reg;
  logic step_rise;

  // Remember last Step level so only a rising edge releases PAUSE.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) step_prev_reg <= 1'b0;
    else        step_prev_reg <= Step;
  end

  assign step_rise = Step && !step_prev_reg;
`endif

  // State register, opcode latch (end of T2) and sticky memory fault.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_reg     <= ST_T0;
      opcode_reg    <= '0;
      mem_fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_T2) begin
        opcode_reg <= IR_opcode;
      end
      if ((state_reg == ST_T1W) && !Mem_ready && timer_expire) begin
        mem_fault_reg <= 1'b1;
      end
    end
  end

  // Next-state logic: Stop is honoured only at an instruction boundary.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_T0:  state_next = Stop ? ST_HALTED : ST_T1;
      ST_T1:  state_next = Mem_ready ? ST_T2 : ST_T1W;
      ST_T1W: begin
        if (Mem_ready)         state_next = ST_T2;
        else if (timer_expire) state_next = ST_HALTED;
        else                   state_next = ST_T1W;
      end
      ST_T2:  state_next = ST_T3;
      ST_T3: begin
        if (opcode_reg == OP_HALT)      state_next = ST_HALTED;
        else if (is_alu_op(opcode_reg)) state_next = ST_T4;
        else                            state_next = DONE_STATE;
      end
      ST_T4:  state_next = ST_T5;
      ST_T5:  state_next = DONE_STATE;
`ifdef CU_SINGLE_STEP_EN
      ST_PAUSE: begin
        if (Stop)           state_next = ST_HALTED;
        else if (step_rise) state_next = ST_T0;
        else                state_next = ST_PAUSE;
      end
`endif
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_T0;
    endcase
  end

  // Moore strobe decode from state and latched opcode, gated by Clear.
  always_comb begin
    PCout          = 1'b0;
    MAR_enable     = 1'b0;
    IncPC          = 1'b0;
    PC_enable      = 1'b0;
    ZLowIn         = 1'b0;
    ZLowout        = 1'b0;
    MDR_read       = 1'b0;
    MDR_enable     = 1'b0;
    MDRout         = 1'b0;
    IR_enable      = 1'b0;
    Gra            = 1'b0;
    Grb            = 1'b0;
    Grc            = 1'b0;
    R_in           = 1'b0;
    R_out          = 1'b0;
    Y_enable       = 1'b0;
    InPortout      = 1'b0;
    OutPort_enable = 1'b0;
    HIout          = 1'b0;
    LOout          = 1'b0;
    ALU_op         = '0;
    Run            = (state_reg != ST_HALTED);
    if (Clear) begin
      case (state_reg)
        ST_T0: begin
          PCout      = 1'b1;
          MAR_enable = 1'b1;
          IncPC      = 1'b1;
          ZLowIn     = 1'b1;
        end
        ST_T1: begin
          ZLowout    = 1'b1;
          PC_enable  = 1'b1;
          MDR_read   = 1'b1;
          MDR_enable = 1'b1;
        end
        ST_T1W: begin
          MDR_read   = 1'b1;
          MDR_enable = 1'b1;
        end
        ST_T2: begin
          MDRout    = 1'b1;
          IR_enable = 1'b1;
        end
        ST_T3: begin
          case (opcode_reg)
            OP_IN: begin
              Gra = 1'b1; R_in = 1'b1; InPortout = 1'b1;
            end
            OP_OUT: begin
              Gra = 1'b1; R_out = 1'b1; OutPort_enable = 1'b1;
            end
            OP_MFHI: begin
              Gra = 1'b1; R_in = 1'b1; HIout = 1'b1;
            end
            OP_MFLO: begin
              Gra = 1'b1; R_in = 1'b1; LOout = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              Grb = 1'b1; R_out = 1'b1; Y_enable = 1'b1;
            end
            default: ;
          endcase
        end
        ST_T4: begin
          Grc    = 1'b1;
          R_out  = 1'b1;
          ZLowIn = 1'b1;
          ALU_op = opcode_reg;
        end
        ST_T5: begin
          ZLowout = 1'b1;
          Gra     = 1'b1;
          R_in    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Mem_fault = mem_fault_reg;

endmodule
